// File: rtl/dlx_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// dlx_hazard_ctrl_if
// Bundle between the DLX pipeline datapath (master) and the hazard controller
// (slave).
//   master drives : mem_ready, id_valid, id_rs1/2, id_use_rs1/2, id_rd,
//                   id_wr_en, id_is_load, ex_redirect
//   slave drives  : stall_id, hold_all, flush_if, flush_id, fwd_a_sel,
//                   fwd_b_sel, stall_count, flush_count
// -----------------------------------------------------------------------------
interface dlx_hazard_ctrl_if #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
);
    logic             mem_ready;
    logic             id_valid;
    logic [RA_W-1:0]  id_rs1;
    logic [RA_W-1:0]  id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [RA_W-1:0]  id_rd;
    logic             id_wr_en;
    logic             id_is_load;
    logic             ex_redirect;

    logic             stall_id;
    logic             hold_all;
    logic             flush_if;
    logic             flush_id;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output mem_ready, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wr_en, id_is_load, ex_redirect,
        input  stall_id, hold_all, flush_if, flush_id, fwd_a_sel, fwd_b_sel,
               stall_count, flush_count
    );

    modport slave (
        input  mem_ready, id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rd, id_wr_en, id_is_load, ex_redirect,
        output stall_id, hold_all, flush_if, flush_id, fwd_a_sel, fwd_b_sel,
               stall_count, flush_count
    );
endinterface

// File: rtl/dlx_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// dlx_hazard_ctrl
// Hazard detection, forwarding-select generation and flush control for a
// five-stage DLX pipeline. A shadow copy of the EX/MEM/WB destination info is
// kept here so the datapath only has to present the ID instruction.
//
// Ports:
//   clock  : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : dlx_hazard_ctrl_if.slave (ID fields, mem_ready, ex_redirect in;
//            stall/flush/hold, forward selects, event counters out)
//
// Configuration:
//   DLX_HAZARD_FWD_EN defined   -> forwarding datapath present; only load-use
//                                  hazards stall, forward selects are live.
//   DLX_HAZARD_FWD_EN undefined -> no forwarding; any in-flight producer of a
//                                  used source stalls, forward selects are 00.
// -----------------------------------------------------------------------------
module dlx_hazard_ctrl #(
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input logic              clock,
    input logic              reset,
    dlx_hazard_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam int EX  = 0;
    localparam int MEM = 1;
    localparam int WB  = 2;

`ifdef DLX_HAZARD_FWD_EN
    // With forwarding only EX and MEM producers matter at ID.
    localparam int HIT_DEPTH = 2;
`else
    localparam int HIT_DEPTH = 3;
`endif

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
        logic            wr_en;
        logic            is_load;
    } entry_t;

    entry_t                 shadow_q [3];
    entry_t                 id_entry;
    logic                   use_a;
    logic                   use_b;
    logic [HIT_DEPTH-1:0]   hit_a;
    logic [HIT_DEPTH-1:0]   hit_b;
    logic                   accept_redirect;
    logic                   stall_raw;
    logic                   stall_id;
    logic                   enter_ex;
    logic [CNT_W-1:0]       stall_cnt_q;
    logic [CNT_W-1:0]       flush_cnt_q;

    // A shadow entry only produces a value if it is a real instruction that
    // writes a register other than r0; a r0 source therefore never matches.
    function automatic logic is_hit(input entry_t e, input logic used,
                                    input logic [RA_W-1:0] src);
        return used && e.valid && e.wr_en && (e.rd != '0) && (e.rd == src);
    endfunction

    // Hazard detection. A redirect squashes the ID instruction anyway, so it
    // overrides any stall; while memory is busy the redirect is not accepted.
    always_comb begin
        use_a = bus.id_valid && bus.id_use_rs1;
        use_b = bus.id_valid && bus.id_use_rs2;
        for (int i = 0; i < HIT_DEPTH; i++) begin
            hit_a[i] = is_hit(shadow_q[i], use_a, bus.id_rs1);
            hit_b[i] = is_hit(shadow_q[i], use_b, bus.id_rs2);
        end
        accept_redirect = bus.ex_redirect && bus.mem_ready;
`ifdef DLX_HAZARD_FWD_EN
        stall_raw = shadow_q[EX].is_load && (hit_a[EX] || hit_b[EX]);
`else
        stall_raw = (|hit_a) || (|hit_b);
`endif
        stall_id = stall_raw && !accept_redirect;
        enter_ex = bus.id_valid && !stall_id && !accept_redirect;

        id_entry.valid   = 1'b1;
        id_entry.rd      = bus.id_rd;
        id_entry.wr_en   = bus.id_wr_en;
        id_entry.is_load = bus.id_is_load;
    end

    assign bus.stall_id = stall_id;
    assign bus.hold_all = !bus.mem_ready;
    assign bus.flush_if = accept_redirect;
    assign bus.flush_id = accept_redirect;

    // Shadow pipeline: advances with the real pipeline, frozen while memory
    // is busy; stalled or flushed ID slots become bubbles in EX.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (bus.mem_ready) begin
            shadow_q[WB]  <= shadow_q[MEM];
            shadow_q[MEM] <= shadow_q[EX];
            shadow_q[EX]  <= enter_ex ? id_entry : '0;
        end
    end

`ifdef DLX_HAZARD_FWD_EN
    logic [1:0] fwd_a_q;
    logic [1:0] fwd_b_q;

    // Selection is made at ID but names the stage the producer will occupy
    // once this instruction is in EX: today's EX producer sits in MEM (01),
    // today's MEM producer sits in WB (10). The youngest match wins.
    function automatic logic [1:0] pick_src(input logic hit_ex, input logic hit_mem);
        if (hit_ex) begin
            return 2'b01;
        end else if (hit_mem) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else if (bus.mem_ready) begin
            fwd_a_q <= enter_ex ? pick_src(hit_a[EX], hit_a[MEM]) : 2'b00;
            fwd_b_q <= enter_ex ? pick_src(hit_b[EX], hit_b[MEM]) : 2'b00;
        end
    end

    assign bus.fwd_a_sel = fwd_a_q;
    assign bus.fwd_b_sel = fwd_b_q;
`else
    assign bus.fwd_a_sel = 2'b00;
    assign bus.fwd_b_sel = 2'b00;
`endif

    // Saturating event counters; a frozen pipeline neither stalls nor
    // flushes, so nothing is counted while memory is busy.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (bus.mem_ready) begin
            if (stall_id && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (accept_redirect && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;

endmodule
